// File: rtl/roi_scan_pkg.sv
// Shared types and default sizes for the ROI serial scan harness.
package roi_scan_pkg;

  localparam int DEF_DIN_N  = 256;
  localparam int DEF_DOUT_N = 256;
  localparam int CNT_W      = $clog2(DEF_DIN_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  function automatic logic is_full(input state_t s);
    return (s == FULL);
  endfunction

endpackage

// File: rtl/roi_scan_fillcnt.sv
// Saturating fill counter and IDLE/FILL/FULL tracker for the input shift chain.
module roi_scan_fillcnt
  import roi_scan_pkg::*;
#(
  parameter int FULL_N = DEF_DIN_N,
  parameter int CW     = $clog2(FULL_N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb,
  input  logic          advance,
  output logic [CW-1:0] fill_cnt,
  output state_t        state
);

  localparam logic [CW-1:0] FULL_CNT = CW'(FULL_N);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_nxt;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt;

  // Next count and state; the bit shifted on a strobe cycle starts the next word
  always_comb begin
    cnt_nxt   = cnt_r;
    state_nxt = state_r;
    if (stb) begin
      cnt_nxt   = ONE_CNT;
      state_nxt = FILL;
    end else if (advance) begin
      if (cnt_r == FULL_CNT) begin
        cnt_nxt = cnt_r;
      end else begin
        cnt_nxt = cnt_r + ONE_CNT;
      end
      case (state_r)
        IDLE, FILL: begin
          if (cnt_nxt == FULL_CNT) begin
            state_nxt = FULL;
          end else begin
            state_nxt = FILL;
          end
        end
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end else begin
      cnt_nxt   = cnt_r;
      state_nxt = state_r;
    end
  end

  // Count and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      state_r <= IDLE;
    end else begin
      cnt_r   <= cnt_nxt;
      state_r <= state_nxt;
    end
  end

  assign fill_cnt = cnt_r;
  assign state    = state_r;

endmodule

// File: rtl/roi_scan_io.sv
// Serial scan harness around the fuzzer ROI: one continuous chain di -> dout_ser,
// with parallel commit/capture on stb and detection of under-filled commits.
module roi_scan_io
  import roi_scan_pkg::*;
#(
  parameter int DIN_N  = DEF_DIN_N,
  parameter int DOUT_N = DEF_DOUT_N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       di,
  input  logic                       stb,
  output logic [DIN_N-1:0]           din,
  input  logic [DOUT_N-1:0]          dout,
  output logic                       dout_ser,
  output logic [$clog2(DIN_N+1)-1:0] fill_cnt,
  output logic                       commit_ok,
  output logic                       short_err
);

  localparam int CW = $clog2(DIN_N + 1);

  logic [DIN_N-1:0]  din_shr_r;
  logic [DOUT_N-1:0] dout_shr_r;
  logic [DIN_N-1:0]  din_r;
  logic              commit_ok_r;
  logic              short_err_r;
  logic [CW-1:0]     fill_cnt_s;
  state_t            state_s;

  roi_scan_fillcnt #(
    .FULL_N (DIN_N),
    .CW     (CW)
  ) u_fillcnt (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .advance  (1'b1),
    .fill_cnt (fill_cnt_s),
    .state    (state_s)
  );

  // Shift chains plus commit/capture; the input chain keeps shifting on stb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_shr_r   <= {DIN_N{1'b0}};
      dout_shr_r  <= {DOUT_N{1'b0}};
      din_r       <= {DIN_N{1'b0}};
      commit_ok_r <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      din_shr_r <= {din_shr_r[DIN_N-2:0], di};
      if (stb) begin
        din_r      <= din_shr_r;
        dout_shr_r <= dout;
      end else begin
        din_r      <= din_r;
        dout_shr_r <= {dout_shr_r[DOUT_N-2:0], din_shr_r[DIN_N-1]};
      end
      commit_ok_r <= stb && is_full(state_s);
      short_err_r <= short_err_r | (stb && !is_full(state_s));
    end
  end

  assign din       = din_r;
  assign dout_ser  = dout_shr_r[DOUT_N-1];
  assign fill_cnt  = fill_cnt_s;
  assign commit_ok = commit_ok_r;
  assign short_err = short_err_r;

endmodule
